// File: rtl/div16x8_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// div16x8_seq
//   Sequential unsigned divider: 16-bit dividend / 8-bit divisor giving a
//   16-bit quotient and an 8-bit remainder. Restoring shift-subtract, one
//   quotient bit per clock, with a start/busy/done handshake. Used to undo a
//   product formed by the 8x8 multiplier.
//
//   Timing: start accepted at edge N, sixteen iterations on edges N+1..N+16,
//   done pulses for the cycle after edge N+16. A zero divisor short-cuts to
//   the DONE state on the accepting edge (done one cycle after start).
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous, active-high reset (aborts any division)
//   start      in   1   request, honoured only when not busy
//   dividend   in   16  unsigned dividend, captured on acceptance
//   divisor    in   8   unsigned divisor, captured on acceptance
//   busy       out  1   high while iterating
//   done       out  1   one-cycle pulse when results become valid
//   quotient   out  16  registered quotient (16'hFFFF on divide-by-zero)
//   remainder  out  8   registered remainder (dividend[7:0] on divide-by-zero)
//   div_zero   out  1   registered; captured divisor was zero
//   chk_err    out  1   sticky self-check error (only with DIV_SELFCHECK_EN)
//
// Build option
//   DIV_SELFCHECK_EN : when defined, adds chk_err and a reconstruction check
//                      quotient*divisor+remainder == dividend, remainder <
//                      divisor, evaluated in the DONE cycle (not for /0).
// -----------------------------------------------------------------------------
module div16x8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_zero
`ifdef DIV_SELFCHECK_EN
  ,
  output logic        chk_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [15:0] dvd_sh;    // dividend shifting out, quotient bits shifting in
  logic [7:0]  dvs;       // captured divisor
  logic [8:0]  rem_acc;   // partial remainder
  logic [3:0]  cnt;       // iteration index 0..15

  logic        accept;
  logic        dvs_is_zero;
  logic        last_step;
  logic [9:0]  step;
  logic        qbit;
  logic [8:0]  rem_nxt;

  // One restoring iteration: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Only the low 8 bits of the
  // previous remainder matter because a restored remainder is always < dvs.
  // Returns {qbit, new_rem}.
  function automatic logic [9:0] div_step(input logic [7:0] rem_lo,
                                          input logic       msb,
                                          input logic [7:0] d);
    logic [8:0] t;
    t = {rem_lo, msb};
    if (t >= {1'b0, d}) div_step = {1'b1, t - {1'b0, d}};
    else                div_step = {1'b0, t};
  endfunction

  assign accept      = start && (state != CALC);
  assign dvs_is_zero = (divisor == 8'd0);
  assign last_step   = (state == CALC) && (cnt == 4'd15);

  assign step    = div_step(rem_acc[7:0], dvd_sh[15], dvs);
  assign qbit    = step[9];
  assign rem_nxt = step[8:0];

  // rem_acc[8] is always zero after a restoring step; the ninth bit exists so
  // the trial value t is formed without overflow, and is otherwise not read.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_acc[8];

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- FSM: next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_nxt = dvs_is_zero ? DONE : CALC;
        else       state_nxt = IDLE;
      end
      CALC:    state_nxt = (cnt == 4'd15) ? DONE : CALC;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // ---- Iteration control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= 4'd0;
    else if (accept)         cnt <= 4'd0;
    else if (state == CALC)  cnt <= cnt + 4'd1;
  end

  // ---- Working datapath (no reset: always loaded before use) ----
  always_ff @(posedge clk) begin
    if (accept && !dvs_is_zero) begin
      dvd_sh  <= dividend;
      dvs     <= divisor;
      rem_acc <= 9'd0;
    end else if (state == CALC) begin
      dvd_sh  <= {dvd_sh[14:0], qbit};
      rem_acc <= rem_nxt;
    end
  end

  // ---- Result registers ----
  // Results change only on a completion edge: the final iteration, or the
  // accepting edge of a divide-by-zero (which is its own completion).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= 16'd0;
      remainder <= 8'd0;
      div_zero  <= 1'b0;
    end else if (accept && dvs_is_zero) begin
      quotient  <= 16'hFFFF;
      remainder <= dividend[7:0];
      div_zero  <= 1'b1;
    end else if (last_step) begin
      quotient  <= {dvd_sh[14:0], qbit};
      remainder <= rem_nxt[7:0];
      div_zero  <= 1'b0;
    end
  end

`ifdef DIV_SELFCHECK_EN
  // ---- Self-check: reconstruct the dividend during the DONE cycle ----
  logic [15:0] dvd_cap;
  logic [23:0] recon;

  always_ff @(posedge clk) begin
    if (accept && !dvs_is_zero) dvd_cap <= dividend;
  end

  assign recon = ({8'd0, quotient} * {16'd0, dvs}) + {16'd0, remainder};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if ((state == DONE) && !div_zero &&
                 ((recon != {8'd0, dvd_cap}) || (remainder >= dvs))) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule
